// File: rtl/mcpu_ctrl.sv
// Multi-cycle main controller for the MIPS-subset CPU: FETCH/DECODE/EXEC/MEMACC/WBACK sequencing.
// Optional macro MCPU_ADDIU_EN adds addiu (001001); without it that opcode decodes as illegal.
module mcpu_ctrl #(
  parameter bit IDLE_RETIRE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic [1:0]  ExtOp,
  output logic [1:0]  ALUOp,
  output logic [1:0]  NPCOp,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEMACC, S_WBACK
  } state_t;

  state_t state, state_nx;

  logic is_rtype, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_addiu;
  logic legal, retire;
  logic       i_regdst, i_alusrc;
  logic [1:0] i_extop, i_aluop;

  assign is_rtype = (opcode == 6'b000000);
  assign is_addu  = is_rtype && (funct == 6'b100001);
  assign is_subu  = is_rtype && (funct == 6'b100011);
  assign is_ori   = (opcode == 6'b001101);
  assign is_lui   = (opcode == 6'b001111);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_j     = (opcode == 6'b000010);
`ifdef MCPU_ADDIU_EN
  assign is_addiu = (opcode == 6'b001001);
`else
  assign is_addiu = 1'b0;
`endif

  assign legal = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw |
                 is_beq | is_j | is_addiu;

  // Per-instruction datapath selects, held from DECODE to the last state.
  always_comb begin
    i_regdst = is_addu | is_subu;
    i_alusrc = is_ori | is_lui | is_lw | is_sw | is_addiu;
    i_extop  = 2'b00;
    if (is_lui)
      i_extop = 2'b10;
    else if (is_lw | is_sw | is_beq | is_addiu)
      i_extop = 2'b01;
    i_aluop  = 2'b00;
    if (is_subu | is_beq)
      i_aluop = 2'b01;
    else if (is_ori)
      i_aluop = 2'b10;
  end

  // Outputs are decoded combinationally and forced low while reset is held.
  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    MemWr    = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    ExtOp    = 2'b00;
    ALUOp    = 2'b00;
    NPCOp    = 2'b00;
    illegal  = 1'b0;
    if (rst_n) begin
      if (state != S_FETCH) begin
        RegDst = i_regdst;
        ALUSrc = i_alusrc;
        ExtOp  = i_extop;
        ALUOp  = i_aluop;
      end
      case (state)
        S_FETCH: begin
          PCWr = 1'b1;
          IRWr = 1'b1;
        end
        S_DECODE: begin
          if (is_j) begin
            PCWr  = 1'b1;
            NPCOp = 2'b10;
          end
          illegal = ~legal;
        end
        S_EXEC: begin
          if (is_beq) begin
            PCWr  = zero;
            NPCOp = 2'b01;
          end
        end
        S_MEMACC: MemWr = is_sw;
        S_WBACK: begin
          RegWr    = 1'b1;
          MemtoReg = is_lw;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = S_FETCH;
    retire   = 1'b0;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        if (is_j) begin
          retire = 1'b1;
        end else if (!legal) begin
          retire = IDLE_RETIRE;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq)
          retire = 1'b1;
        else if (is_lw | is_sw)
          state_nx = S_MEMACC;
        else
          state_nx = S_WBACK;
      end
      S_MEMACC: begin
        if (is_sw)
          retire = 1'b1;
        else
          state_nx = S_WBACK;
      end
      S_WBACK: retire = 1'b1;
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      instr_cnt <= 32'd0;
    end else begin
      state <= state_nx;
      if (retire)
        instr_cnt <= instr_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Scoreboard bench for mcpu_ctrl: stimulus pushes per-cycle expected outputs, a negedge monitor compares.
module tb_mcpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        PCWr, IRWr, RegWr, MemWr, RegDst, ALUSrc, MemtoReg, illegal;
  logic [1:0]  ExtOp, ALUOp, NPCOp;
  logic [31:0] instr_cnt;

  mcpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ExtOp(ExtOp), .ALUOp(ALUOp),
    .NPCOp(NPCOp), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] vec;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ecnt;

  // Vector layout: PCWr IRWr RegWr MemWr RegDst ALUSrc MemtoReg ExtOp ALUOp NPCOp illegal
  function automatic logic [13:0] v(input logic pc, ir, rw, mw, rd, as, m2r,
                                    input logic [1:0] ext, alu, npc, input logic ill);
    return {pc, ir, rw, mw, rd, as, m2r, ext, alu, npc, ill};
  endfunction

  task automatic push(input logic [13:0] vec, input string name);
    exp_t e;
    e.vec = vec; e.cnt = ecnt; e.name = name;
    q.push_back(e);
  endtask

  task automatic start(input logic [5:0] op, input logic [5:0] fn, input logic z, input string name);
    opcode = op; funct = fn; zero = z;
    push(v(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), {name, "_fetch"});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [13:0] act;
      e = q.pop_front();
      act = {PCWr, IRWr, RegWr, MemWr, RegDst, ALUSrc, MemtoReg, ExtOp, ALUOp, NPCOp, illegal};
      checks++;
      if (act !== e.vec) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b", e.name, act, e.vec);
      end
      checks++;
      if (instr_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s instr_cnt got %0d want %0d", e.name, instr_cnt, e.cnt);
      end
    end
  end

  initial begin
    logic [13:0] d;
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; ecnt = 32'd0;
    cycles(1);
    push(14'd0, "reset");
    cycles(1);
    rst_n = 1'b1;

    // ori
    start(6'b001101, 6'd0, 0, "ori");
    d = v(0,0,0,0,0,1,0,2'b00,2'b10,2'b00,0);
    push(d, "ori_dec"); push(d, "ori_exec");
    push(v(0,0,1,0,0,1,0,2'b00,2'b10,2'b00,0), "ori_wb");
    cycles(4); ecnt++;

    // addu aborted by reset during WBACK
    start(6'b000000, 6'b100001, 0, "addu_abort");
    d = v(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0);
    push(d, "addu_abort_dec"); push(d, "addu_abort_exec");
    cycles(3);
    rst_n = 1'b0; ecnt = 32'd0;
    push(14'd0, "reset_mid_wb");
    cycles(1);
    rst_n = 1'b1;

    // addu
    start(6'b000000, 6'b100001, 0, "addu");
    d = v(0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0);
    push(d, "addu_dec"); push(d, "addu_exec");
    push(v(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0), "addu_wb");
    cycles(4); ecnt++;

    // subu
    start(6'b000000, 6'b100011, 0, "subu");
    d = v(0,0,0,0,1,0,0,2'b00,2'b01,2'b00,0);
    push(d, "subu_dec"); push(d, "subu_exec");
    push(v(0,0,1,0,1,0,0,2'b00,2'b01,2'b00,0), "subu_wb");
    cycles(4); ecnt++;

    // lui
    start(6'b001111, 6'd0, 0, "lui");
    d = v(0,0,0,0,0,1,0,2'b10,2'b00,2'b00,0);
    push(d, "lui_dec"); push(d, "lui_exec");
    push(v(0,0,1,0,0,1,0,2'b10,2'b00,2'b00,0), "lui_wb");
    cycles(4); ecnt++;

    // lw
    start(6'b100011, 6'd0, 0, "lw");
    d = v(0,0,0,0,0,1,0,2'b01,2'b00,2'b00,0);
    push(d, "lw_dec"); push(d, "lw_exec"); push(d, "lw_mem");
    push(v(0,0,1,0,0,1,1,2'b01,2'b00,2'b00,0), "lw_wb");
    cycles(5); ecnt++;

    // beq taken
    start(6'b000100, 6'd0, 1, "beq_t");
    push(v(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,0), "beq_t_dec");
    push(v(1,0,0,0,0,0,0,2'b01,2'b01,2'b01,0), "beq_t_exec");
    cycles(3); ecnt++;

    // beq not taken
    start(6'b000100, 6'd0, 0, "beq_nt");
    push(v(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,0), "beq_nt_dec");
    push(v(0,0,0,0,0,0,0,2'b01,2'b01,2'b01,0), "beq_nt_exec");
    cycles(3); ecnt++;

    // j
    start(6'b000010, 6'd0, 0, "j");
    push(v(1,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), "j_dec");
    cycles(2); ecnt++;

    // sw
    start(6'b101011, 6'd0, 0, "sw");
    d = v(0,0,0,0,0,1,0,2'b01,2'b00,2'b00,0);
    push(d, "sw_dec"); push(d, "sw_exec");
    push(v(0,0,0,1,0,1,0,2'b01,2'b00,2'b00,0), "sw_mem");
    cycles(4); ecnt++;

    // R-type with unsupported funct
    start(6'b000000, 6'b100000, 0, "rt_ill");
    push(v(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1), "rt_ill_dec");
    cycles(2);

    // opcode 001001
`ifdef MCPU_ADDIU_EN
    start(6'b001001, 6'd0, 0, "addiu");
    d = v(0,0,0,0,0,1,0,2'b01,2'b00,2'b00,0);
    push(d, "addiu_dec"); push(d, "addiu_exec");
    push(v(0,0,1,0,0,1,0,2'b01,2'b00,2'b00,0), "addiu_wb");
    cycles(4); ecnt++;
`else
    start(6'b001001, 6'd0, 0, "addiu_ill");
    push(v(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1), "addiu_ill_dec");
    cycles(2);
`endif

    // trailing j exposes the final count
    start(6'b000010, 6'd0, 0, "j2");
    push(v(1,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), "j2_dec");
    cycles(2); ecnt++;

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
